// File: rtl/axis_cplx_pkg.sv
// Shared types and default sizes for the complex AXI4-Stream frame transmitter.
package axis_cplx_pkg;
    localparam int DATA_BW_DEF = 16;
    localparam int DEPTH_DEF   = 1024;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} tx_state_t;

    // Field names avoid the reserved word 'real'.
    typedef struct packed {
        logic signed [DATA_BW_DEF-1:0] re;
        logic signed [DATA_BW_DEF-1:0] im;
    } cplx_t;
endpackage

// File: rtl/axis_cplx_frame_tx_if.sv
// AXI4-Stream bundle carrying one complex sample per beat, framed by tlast.
interface axis_cplx_frame_tx_if
    import axis_cplx_pkg::*;
#(
    parameter int DATA_BW = DATA_BW_DEF
);
    logic               tvalid;
    logic               tready;
    logic [DATA_BW-1:0] tdata_real;
    logic [DATA_BW-1:0] tdata_imag;
    logic               tlast;

    modport master (output tvalid, output tdata_real, output tdata_imag, output tlast, input tready);
    modport slave  (input tvalid, input tdata_real, input tdata_imag, input tlast, output tready);
endinterface

// File: rtl/axis_cplx_frame_ram.sv
// Simple dual-port sample buffer with a registered, read-first read port.
module axis_cplx_frame_ram #(
    parameter int  WIDTH   = 32,
    parameter int  DEPTH   = 1024,
    localparam int ADDR_BW = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_BW-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [ADDR_BW-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // A same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/axis_cplx_frame_tx.sv
// Plays a reloadable complex sample buffer out as tlast-delimited AXI4-Stream frames.
// Optional stall counter enabled by defining AXIS_CPLX_FRAME_TX_STALL_CNT_EN.
module axis_cplx_frame_tx
    import axis_cplx_pkg::*;
#(
    parameter int  DATA_BW = DATA_BW_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    localparam int ADDR_BW = $clog2(DEPTH)
) (
    input  logic               m_axis_aclk,
    input  logic               m_axis_aresetn,
    input  logic               wr_en,
    input  logic [ADDR_BW-1:0] wr_addr,
    input  logic [DATA_BW-1:0] wr_data_real,
    input  logic [DATA_BW-1:0] wr_data_imag,
    input  logic               start,
    input  logic               stop,
    input  logic [ADDR_BW:0]   frame_len,
    input  logic [15:0]        num_frames,
    output logic               busy,
    output logic               done,
`ifdef AXIS_CPLX_FRAME_TX_STALL_CNT_EN
    output logic [31:0]        stall_cnt,
`endif
    axis_cplx_frame_tx_if.master m_axis
);
    localparam int               SW      = 2 * DATA_BW;
    localparam logic [ADDR_BW:0] DEPTH_L = (ADDR_BW+1)'(DEPTH);

    tx_state_t          state, state_nxt;
    logic [ADDR_BW-1:0] len_m1, rd_addr;
    logic [15:0]        nf, out_frame;
    logic               stop_pend;
    logic               rd_en, rd_valid, rd_last;
    logic [SW-1:0]      ram_dout;
    logic [1:0]         fifo_cnt;
    logic [SW-1:0]      e0_data, e1_data;
    logic               e0_last, e1_last;
    logic               start_ok, push, pop, final_frame, final_hs;

    axis_cplx_frame_ram #(.WIDTH(SW), .DEPTH(DEPTH)) u_ram (
        .clk     (m_axis_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_data_real, wr_data_imag}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_dout)
    );

    // Reads are throttled only by registered occupancy, so the RAM output register acts as
    // a third storage slot and tready never reaches the read enable.
    always_comb begin
        state_nxt   = state;
        start_ok    = (state == IDLE) && start && (frame_len != '0) && (frame_len <= DEPTH_L);
        pop         = (fifo_cnt != 2'd0) && m_axis.tready;
        push        = rd_valid && (fifo_cnt != 2'd2);
        final_frame = (nf == 16'd0) ? (stop_pend || stop) : (out_frame == nf - 16'd1);
        final_hs    = (state == STREAM) && pop && e0_last && final_frame;
        rd_en       = (state == PRIME) ||
                      ((state == STREAM) && (!rd_valid || (fifo_cnt != 2'd2)));
        case (state)
            IDLE:    if (start_ok) state_nxt = PRIME;
            PRIME:   state_nxt = STREAM;
            STREAM:  if (final_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            state     <= IDLE;
            len_m1    <= '0;
            nf        <= '0;
            out_frame <= '0;
            stop_pend <= 1'b0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                len_m1    <= ADDR_BW'(frame_len - 1'b1);
                nf        <= num_frames;
                out_frame <= '0;
                stop_pend <= 1'b0;
                rd_addr   <= '0;
            end else begin
                if (stop && ((state == PRIME) || (state == STREAM))) stop_pend <= 1'b1;
                if (pop && e0_last) out_frame <= out_frame + 16'd1;
                if (rd_en) rd_addr <= (rd_addr == len_m1) ? '0 : rd_addr + 1'b1;
            end
            if (final_hs)  rd_valid <= 1'b0;
            else if (rd_en) rd_valid <= 1'b1;
            else if (push)  rd_valid <= 1'b0;
            if (rd_en) rd_last <= (rd_addr == len_m1);
        end
    end

    // Two-entry skid buffer; prefetched samples beyond the final frame are dropped on exit.
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            fifo_cnt <= 2'd0;
            e0_data  <= '0;
            e0_last  <= 1'b0;
            e1_data  <= '0;
            e1_last  <= 1'b0;
        end else if (final_hs) begin
            fifo_cnt <= 2'd0;
        end else begin
            case (fifo_cnt)
                2'd0: if (push) begin
                    e0_data  <= ram_dout;
                    e0_last  <= rd_last;
                    fifo_cnt <= 2'd1;
                end
                2'd1: if (push && pop) begin
                    e0_data <= ram_dout;
                    e0_last <= rd_last;
                end else if (push) begin
                    e1_data  <= ram_dout;
                    e1_last  <= rd_last;
                    fifo_cnt <= 2'd2;
                end else if (pop) begin
                    fifo_cnt <= 2'd0;
                end
                2'd2: if (pop) begin
                    e0_data  <= e1_data;
                    e0_last  <= e1_last;
                    fifo_cnt <= 2'd1;
                end
                default: fifo_cnt <= 2'd0;
            endcase
        end
    end

    assign m_axis.tvalid     = (fifo_cnt != 2'd0);
    assign m_axis.tdata_real = e0_data[SW-1 -: DATA_BW];
    assign m_axis.tdata_imag = e0_data[DATA_BW-1:0];
    assign m_axis.tlast      = e0_last;
    assign busy              = (state == PRIME) || (state == STREAM);
    assign done              = (state == DONE);

`ifdef AXIS_CPLX_FRAME_TX_STALL_CNT_EN
    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn || start_ok) stall_cnt <= '0;
        else if (m_axis.tvalid && !m_axis.tready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_axis_cplx_frame_tx.sv
// Self-checking bench for axis_cplx_frame_tx: table-driven playback configurations plus
// hand-written corner sequences, checked against a frame-level memory model.
module tb_axis_cplx_frame_tx;
    import axis_cplx_pkg::*;

    localparam int DATA_BW = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_BW = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               wr_en = 1'b0;
    logic [ADDR_BW-1:0] wr_addr = '0;
    logic [DATA_BW-1:0] wr_data_real = '0;
    logic [DATA_BW-1:0] wr_data_imag = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [ADDR_BW:0]   frame_len = '0;
    logic [15:0]        num_frames = '0;
    logic               busy, done;
`ifdef AXIS_CPLX_FRAME_TX_STALL_CNT_EN
    logic [31:0]        stall_cnt;
`endif

    axis_cplx_frame_tx_if #(.DATA_BW(DATA_BW)) m_axis ();

    axis_cplx_frame_tx #(.DATA_BW(DATA_BW), .DEPTH(DEPTH)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rstn),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data_real   (wr_data_real),
        .wr_data_imag   (wr_data_imag),
        .start          (start),
        .stop           (stop),
        .frame_len      (frame_len),
        .num_frames     (num_frames),
        .busy           (busy),
        .done           (done),
`ifdef AXIS_CPLX_FRAME_TX_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .m_axis         (m_axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int nf;
        bit rnd;
        int stop_beat;
        int exp_beats;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    cplx_t model_mem [DEPTH];

    // Playback hooks: mid-stream write, start-while-busy and start-on-done pokes.
    int    hook_beat = -1;
    int    hook_addr = 0;
    int    hook_defer = -1;
    cplx_t hook_val;
    bit    hook_pending = 1'b0;
    bit    poke_busy = 1'b0;
    bit    poke_done = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_mem(input int addr, input cplx_t val);
        wr_en        = 1'b1;
        wr_addr      = ADDR_BW'(addr);
        wr_data_real = val.re;
        wr_data_imag = val.im;
        tick();
        wr_en = 1'b0;
        model_mem[addr] = val;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"},   busy, 0);
        check_output({tag, "_done"},   done, 0);
        check_output({tag, "_tvalid"}, m_axis.tvalid, 0);
        check_output({tag, "_tlast"},  m_axis.tlast, 0);
        check_output({tag, "_tdata"},  {m_axis.tdata_real, m_axis.tdata_imag}, 0);
`ifdef AXIS_CPLX_FRAME_TX_STALL_CNT_EN
        check_output({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    // Starts one playback and checks every beat against model_mem[beat % len].
    task automatic apply_stimulus(input int len, input int nf, input bit rnd, input int stop_beat,
                                  input int exp_beats, input string tag);
        int          beat_idx = 0;
        int          cycles = 0;
        int          stalls = 0;
        int          a;
        bit          held = 1'b0;
        bit          hs;
        logic [32:0] held_val = '0;
        logic [32:0] cur_val;
        logic [32:0] exp_val;

        m_axis.tready = 1'b1;
        frame_len     = (ADDR_BW+1)'(len);
        num_frames    = 16'(nf);
        start         = 1'b1;
        tick();
        start = 1'b0;
        check_output({tag, "_busy_rise"}, busy, 1);
        check_output({tag, "_tvalid_n1"}, m_axis.tvalid, 0);
        tick();
        check_output({tag, "_tvalid_n2"}, m_axis.tvalid, 0);
        tick();
        check_output({tag, "_first_tvalid"}, m_axis.tvalid, 1);

        while ((beat_idx < exp_beats) && (cycles < 1000)) begin
            m_axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur_val = {m_axis.tdata_real, m_axis.tdata_imag, m_axis.tlast};
            if (held)
                check_output($sformatf("%s_stall_hold%0d", tag, beat_idx),
                             {m_axis.tvalid, cur_val}, {1'b1, held_val});
            hs   = m_axis.tvalid && m_axis.tready;
            held = m_axis.tvalid && !m_axis.tready;
            if (held) begin
                stalls++;
                held_val = cur_val;
            end
            stop  = hs && (beat_idx == stop_beat);
            start = poke_busy && hs && (beat_idx == 2);
            if (start) begin
                frame_len  = 5'd2;
                num_frames = 16'd7;
            end
            wr_en = 1'b0;
            if (hs && (beat_idx == hook_beat)) begin
                wr_en        = 1'b1;
                wr_addr      = ADDR_BW'(hook_addr);
                wr_data_real = hook_val.re;
                wr_data_imag = hook_val.im;
                if (hook_defer < 0) model_mem[hook_addr] = hook_val;
                else hook_pending = 1'b1;
            end
            if (hs) begin
                a       = beat_idx % len;
                exp_val = {model_mem[a].re, model_mem[a].im, (a == len - 1)};
                check_output($sformatf("%s_beat%0d", tag, beat_idx), cur_val, exp_val);
                beat_idx++;
                if (hook_pending && (beat_idx == hook_defer)) begin
                    model_mem[hook_addr] = hook_val;
                    hook_pending = 1'b0;
                end
            end
            tick();
            cycles++;
        end
        stop  = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        if (beat_idx < exp_beats)
            check_output({tag, "_timeout_beats"}, 64'(beat_idx), 64'(exp_beats));

        check_output({tag, "_done_pulse"}, done, 1);
        check_output({tag, "_busy_fall"}, busy, 0);
        check_output({tag, "_tvalid_after"}, m_axis.tvalid, 0);
`ifdef AXIS_CPLX_FRAME_TX_STALL_CNT_EN
        check_output({tag, "_stall_cnt"}, stall_cnt, 64'(stalls));
`endif
        if (poke_done) begin
            frame_len  = 5'd4;
            num_frames = 16'd1;
            start      = 1'b1;
        end
        tick();
        start = 1'b0;
        check_output({tag, "_done_clear"}, done, 0);
        check_output({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t  vecs [7];
        cplx_t v;
        int    beats, cyc, len, nf;

        vecs[0] = '{len: 8,  nf: 2, rnd: 1'b0, stop_beat: -1, exp_beats: 16};
        vecs[1] = '{len: 8,  nf: 2, rnd: 1'b1, stop_beat: -1, exp_beats: 16};
        vecs[2] = '{len: 4,  nf: 0, rnd: 1'b0, stop_beat: 5,  exp_beats: 8};
        vecs[3] = '{len: 1,  nf: 3, rnd: 1'b0, stop_beat: -1, exp_beats: 3};
        vecs[4] = '{len: 16, nf: 1, rnd: 1'b1, stop_beat: -1, exp_beats: 16};
        vecs[5] = '{len: 3,  nf: 4, rnd: 1'b1, stop_beat: -1, exp_beats: 12};
        vecs[6] = '{len: 5,  nf: 0, rnd: 1'b0, stop_beat: 11, exp_beats: 15};

        m_axis.tready = 1'b1;
        rstn = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rstn = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            if (i < 8) v = '{re: 16'(i), im: 16'(-i)};
            else v = '{re: 16'($urandom), im: 16'($urandom)};
            write_mem(i, v);
        end

        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            poke_busy = (i == 5);
            poke_done = (i == 3);
            apply_stimulus(vecs[i].len, vecs[i].nf, vecs[i].rnd, vecs[i].stop_beat,
                           vecs[i].exp_beats, $sformatf("vec%0d", i));
        end
        poke_busy = 1'b0;
        poke_done = 1'b0;

        frame_len  = 5'd0;
        num_frames = 16'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check_output("len0_busy", busy, 0);
        tick();
        check_output("len0_tvalid", m_axis.tvalid, 0);
        frame_len = 5'd17;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check_output("len17_busy", busy, 0);

        frame_len     = 5'd8;
        num_frames    = 16'd1;
        m_axis.tready = 1'b1;
        start         = 1'b1;
        tick();
        start = 1'b0;
        beats = 0;
        cyc   = 0;
        while ((beats < 3) && (cyc < 50)) begin
            if (m_axis.tvalid && m_axis.tready) beats++;
            tick();
            cyc++;
        end
        check_output("midreset_beat3", {m_axis.tvalid, m_axis.tdata_real, m_axis.tdata_imag},
                     {1'b1, model_mem[3].re, model_mem[3].im});
        rstn = 1'b0;
        tick();
        check_reset_values("midreset");
        rstn = 1'b1;
        tick();
        check_output("postreset_tvalid", m_axis.tvalid, 0);
        apply_stimulus(8, 1, 1'b0, -1, 8, "replay");

        hook_beat  = 1;
        hook_addr  = 5;
        hook_defer = -1;
        hook_val   = '{re: 16'h1234, im: 16'h5678};
        apply_stimulus(8, 1, 1'b0, -1, 8, "livewr");

        hook_beat  = 2;
        hook_addr  = 4;
        hook_defer = 5;
        hook_val   = '{re: 16'h0bad, im: 16'h0cab};
        apply_stimulus(8, 1, 1'b0, -1, 8, "collide");
        hook_beat = -1;
        apply_stimulus(8, 1, 1'b0, -1, 8, "after_collide");

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, DEPTH);
            nf  = $urandom_range(1, 3);
            apply_stimulus(len, nf, 1'b1, -1, len * nf, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
